// File: rtl/hazard_stall_ctrl.sv
// Central stall controller: Tuse/Tnew data hazards, MDU busy sequencing and the
// EPC-before-eret interlock. CP0 Req always wins over stall. Also keeps a saturating stall counter.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int EPC_REG     = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_TuseRs,
    input  logic [1:0]  D_TuseRt,
    input  logic        D_isMD,
    input  logic        D_eret,
    input  logic [4:0]  E_dst,
    input  logic        E_RegWrite,
    input  logic [1:0]  E_timeNew,
    input  logic        E_mdStart,
    input  logic        E_mdIsDiv,
    input  logic        E_CP0Write,
    input  logic [4:0]  E_rd,
    input  logic [4:0]  M_dst,
    input  logic        M_RegWrite,
    input  logic [1:0]  M_timeNew,
    input  logic        M_CP0Write,
    input  logic [4:0]  M_rd,
    output logic        stall,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cycles
);

    localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES);
    localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES);
    localparam logic [4:0] EPC_IDX   = 5'(EPC_REG);

    // A producer only stalls D when its result arrives later than D needs it.
    function automatic logic src_hazard(input logic [4:0] field, input logic [1:0] tuse,
                                        input logic wr, input logic [4:0] dst,
                                        input logic [1:0] tnew);
        return (field != 5'd0) && wr && (dst == field) && (tnew > tuse);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic        data_stall;
    logic        epc_stall;
    logic        md_stall;
    logic [5:0]  md_cnt;
    logic [31:0] stall_cnt;

    assign data_stall = src_hazard(D_rs, D_TuseRs, E_RegWrite, E_dst, E_timeNew)
                      | src_hazard(D_rs, D_TuseRs, M_RegWrite, M_dst, M_timeNew)
                      | src_hazard(D_rt, D_TuseRt, E_RegWrite, E_dst, E_timeNew)
                      | src_hazard(D_rt, D_TuseRt, M_RegWrite, M_dst, M_timeNew);

    assign epc_stall = D_eret & ((E_CP0Write & (E_rd == EPC_IDX)) |
                                 (M_CP0Write & (M_rd == EPC_IDX)));

    assign md_busy  = (md_cnt != 6'd0);
    assign md_done  = (md_cnt == 6'd1);
    assign md_stall = D_isMD & (md_busy | E_mdStart);

    assign stall        = (data_stall | epc_stall | md_stall) & ~Req;
    assign stall_cycles = stall_cnt;

    // Req never aborts a running MDU op; it only blocks a new start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt    <= 6'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (E_mdStart && !md_busy && !Req)
                md_cnt <= E_mdIsDiv ? DIV_LOAD : MULT_LOAD;
            else if (md_busy)
                md_cnt <= md_cnt - 6'd1;
            if (stall)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed and randomized bench for hazard_stall_ctrl against a cycle-indexed
// behavioural model of the stall rules, MDU busy window and saturating stall count.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req;
    logic [4:0]  D_rs, D_rt, E_dst, E_rd, M_dst, M_rd;
    logic [1:0]  D_TuseRs, D_TuseRt, E_timeNew, M_timeNew;
    logic        D_isMD, D_eret, E_RegWrite, E_mdStart, E_mdIsDiv, E_CP0Write;
    logic        M_RegWrite, M_CP0Write;
    logic        stall, md_busy, md_done;
    logic [31:0] stall_cycles;

    int    n_chk  = 0;
    int    n_pass = 0;
    int    edges  = 0;
    int    md_start_e = -1000;
    int    md_len = 0;
    longint sc = 0;

    hazard_stall_ctrl dut (
        .clk(clk), .reset(reset), .Req(Req),
        .D_rs(D_rs), .D_rt(D_rt), .D_TuseRs(D_TuseRs), .D_TuseRt(D_TuseRt),
        .D_isMD(D_isMD), .D_eret(D_eret),
        .E_dst(E_dst), .E_RegWrite(E_RegWrite), .E_timeNew(E_timeNew),
        .E_mdStart(E_mdStart), .E_mdIsDiv(E_mdIsDiv), .E_CP0Write(E_CP0Write), .E_rd(E_rd),
        .M_dst(M_dst), .M_RegWrite(M_RegWrite), .M_timeNew(M_timeNew),
        .M_CP0Write(M_CP0Write), .M_rd(M_rd),
        .stall(stall), .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model: MDU busy is a window of md_len cycles after the start edge.
    function automatic bit m_busy();
        return (edges > md_start_e) && (edges <= md_start_e + md_len);
    endfunction

    function automatic bit m_done();
        return m_busy() && (edges == md_start_e + md_len);
    endfunction

    function automatic bit late(input int field, input int tuse, input bit wr,
                                input int dst, input int tnew);
        return field != 0 && wr && dst == field && tnew > tuse;
    endfunction

    function automatic bit m_stall();
        bit ds, es, ms;
        ds = late(D_rs, D_TuseRs, E_RegWrite, E_dst, E_timeNew) ||
             late(D_rs, D_TuseRs, M_RegWrite, M_dst, M_timeNew) ||
             late(D_rt, D_TuseRt, E_RegWrite, E_dst, E_timeNew) ||
             late(D_rt, D_TuseRt, M_RegWrite, M_dst, M_timeNew);
        es = D_eret && ((E_CP0Write && E_rd == 14) || (M_CP0Write && M_rd == 14));
        ms = D_isMD && (m_busy() || E_mdStart);
        return (ds || es || ms) && !Req;
    endfunction

    // Called just after a negedge with inputs settled; checks, then advances one edge.
    task automatic step();
        bit s, b;
        #1;
        s = m_stall();
        b = m_busy();
        chk("stall", {31'd0, stall}, {31'd0, s});
        chk("md_busy", {31'd0, md_busy}, {31'd0, b});
        chk("md_done", {31'd0, md_done}, {31'd0, m_done()});
        chk("stall_cycles", stall_cycles, 32'(sc));
        @(posedge clk);
        if (s) sc = (sc + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : sc + 1;
        if (E_mdStart && !b && !Req) begin
            md_start_e = edges;
            md_len = E_mdIsDiv ? 10 : 5;
        end
        edges++;
        @(negedge clk);
    endtask

    task automatic idle();
        Req = 0; D_rs = 0; D_rt = 0; D_TuseRs = 3; D_TuseRt = 3; D_isMD = 0; D_eret = 0;
        E_dst = 0; E_RegWrite = 0; E_timeNew = 0; E_mdStart = 0; E_mdIsDiv = 0;
        E_CP0Write = 0; E_rd = 0; M_dst = 0; M_RegWrite = 0; M_timeNew = 0;
        M_CP0Write = 0; M_rd = 0;
    endtask

    task automatic model_reset();
        sc = 0;
        md_start_e = -1000;
        md_len = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic expect_stall(input string tag, input bit v);
        #1;
        chk(tag, {31'd0, stall}, {31'd0, v});
    endtask

    initial begin
        idle();
        do_reset();
        #1;
        chk("rst_busy", {31'd0, md_busy}, 32'd0);
        chk("rst_done", {31'd0, md_done}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_cnt", stall_cycles, 32'd0);
        @(negedge clk);

        // Load-use against E
        D_rs = 5; D_TuseRs = 0; E_dst = 5; E_RegWrite = 1; E_timeNew = 2;
        expect_stall("ld_use", 1); step();
        E_timeNew = 0;
        expect_stall("ld_use_tnew0", 0); step();
        E_timeNew = 2; D_rs = 0; E_dst = 0;
        expect_stall("ld_use_r0", 0); step();
        idle();

        // Hazard against M
        M_dst = 7; M_RegWrite = 1; M_timeNew = 1; D_rt = 7; D_TuseRt = 0;
        expect_stall("m_haz", 1); step();
        D_TuseRt = 1;
        expect_stall("m_haz_tuse1", 0); step();
        idle();

        // Mult timing, D_isMD in start cycle and through the window
        E_mdStart = 1; E_mdIsDiv = 0; D_isMD = 1;
        expect_stall("mul_start_stall", 1); step();
        E_mdStart = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("mul_busy", {31'd0, md_busy}, 32'd1);
            chk("mul_done", {31'd0, md_done}, (i == 4) ? 32'd1 : 32'd0);
            step();
        end
        #1 chk("mul_idle", {31'd0, md_busy}, 32'd0);
        step();
        idle();

        // Div with Req mid-flight, then start blocked by Req
        E_mdStart = 1; E_mdIsDiv = 1; step();
        E_mdStart = 0; D_isMD = 1;
        for (int i = 0; i < 10; i++) begin
            Req = (i == 2 || i == 3);
            #1 chk("div_busy", {31'd0, md_busy}, 32'd1);
            step();
        end
        Req = 0;
        #1 chk("div_idle", {31'd0, md_busy}, 32'd0);
        step();
        E_mdStart = 1; Req = 1; step();
        E_mdStart = 0; Req = 0;
        #1 chk("req_blocks_start", {31'd0, md_busy}, 32'd0);
        step();
        idle();

        // eret / EPC interlock
        D_eret = 1; E_CP0Write = 1; E_rd = 14;
        expect_stall("epc_e", 1); step();
        E_rd = 12;
        expect_stall("epc_e_other", 0); step();
        M_CP0Write = 1; M_rd = 14;
        expect_stall("epc_m", 1); step();
        idle();

        // Seven stall cycles from zero
        do_reset();
        D_rs = 3; D_TuseRs = 0; E_dst = 3; E_RegWrite = 1; E_timeNew = 1;
        repeat (7) step();
        idle();
        #1 chk("cnt7", stall_cycles, 32'd7);
        @(negedge clk);

        // Saturation
        force dut.stall_cnt = 32'hFFFF_FFFD;
        #1 release dut.stall_cnt;
        sc = 64'hFFFF_FFFD;
        @(negedge clk);
        D_rs = 3; D_TuseRs = 0; E_dst = 3; E_RegWrite = 1; E_timeNew = 1;
        repeat (5) step();
        idle();
        #1 chk("cnt_sat", stall_cycles, 32'hFFFF_FFFF);
        @(negedge clk);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            Req        = ($urandom_range(0, 15) == 0);
            D_rs       = 5'($urandom_range(0, 3));
            D_rt       = 5'($urandom_range(0, 3));
            D_TuseRs   = 2'($urandom_range(0, 3));
            D_TuseRt   = 2'($urandom_range(0, 3));
            D_isMD     = ($urandom_range(0, 3) == 0);
            D_eret     = ($urandom_range(0, 7) == 0);
            E_dst      = 5'($urandom_range(0, 3));
            E_RegWrite = 1'($urandom_range(0, 1));
            E_timeNew  = 2'($urandom_range(0, 2));
            E_mdStart  = ($urandom_range(0, 5) == 0);
            E_mdIsDiv  = 1'($urandom_range(0, 1));
            E_CP0Write = ($urandom_range(0, 3) == 0);
            E_rd       = ($urandom_range(0, 1) == 1) ? 5'd14 : 5'($urandom_range(0, 31));
            M_dst      = 5'($urandom_range(0, 3));
            M_RegWrite = 1'($urandom_range(0, 1));
            M_timeNew  = 2'($urandom_range(0, 1));
            M_CP0Write = ($urandom_range(0, 3) == 0);
            M_rd       = ($urandom_range(0, 1) == 1) ? 5'd14 : 5'($urandom_range(0, 31));
            step();
        end
        idle();

        // Asynchronous reset in the middle of a div
        E_mdStart = 1; E_mdIsDiv = 1; D_isMD = 1; step();
        E_mdStart = 0;
        repeat (3) step();
        idle();
        #2 reset = 1;
        #1;
        chk("async_busy", {31'd0, md_busy}, 32'd0);
        chk("async_cnt", stall_cycles, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
